// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle cpu_core: opcodes, instruction field
// positions, default widths and the preloaded Fibonacci program image.
package cpu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int PC_W_DEF   = 8;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_ADC  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_B    = 4'h8,
    OP_HALT = 4'hF
  } opcode_e;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS1_HI = 7;
  localparam int RS1_LO = 4;
  localparam int RS2_HI = 3;
  localparam int RS2_LO = 0;

  // Program image packed little-end first: word i lives at [16*i +: 16].
  localparam int PROG_LEN = 8;
  localparam logic [16*PROG_LEN-1:0] FIB_PROG = {
    16'h0000, 16'h8002, 16'h1230, 16'h1120,
    16'h1310, 16'h1212, 16'h4201, 16'h4101
  };

  function automatic logic is_alu_op(input opcode_e op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADC};
  endfunction

endpackage

// File: rtl/cpu_core_alu.sv
// Combinational ALU; results wrap modulo 2**DATA_W with no flags.
module alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  opcode_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD, OP_ADC: y = a + b;
      OP_SUB:         y = a - b;
      OP_AND:         y = a & b;
      OP_OR:          y = a | b;
      OP_XOR:         y = a ^ b;
      default:        y = '0;
    endcase
  end

endmodule

// File: rtl/cpu_core.sv
// Single-cycle 16-bit-instruction CPU: ROM, register file, PC and decode, with
// a run/halt control FSM. Each unhalted rising edge retires the instruction at pc_o.
module cpu_core
  import cpu_pkg::*;
#(
  parameter int                       DATA_W = DATA_W_DEF,
  parameter int                       PC_W   = PC_W_DEF,
  parameter logic [16*PROG_LEN-1:0]   PROG   = FIB_PROG
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [PC_W-1:0]   pc_o,
  output logic              wr_en_o,
  output logic [3:0]        wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              halt_o
);

  typedef enum logic {ST_RUN, ST_HALTED} state_e;

  state_e            state_q, state_next;
  logic [PC_W-1:0]   pc;
  logic [15:0]       instr;
  opcode_e           opcode;
  logic [3:0]        rd, rs1, rs2;
  logic [DATA_W-1:0] regs [16];
  logic [DATA_W-1:0] a, b, y, imm;
  logic              run, wr_en;

  // Words beyond the program image read as NOP.
  always_comb begin
    instr = '0;
    for (int i = 0; i < PROG_LEN; i++)
      if (int'(pc) == i) instr = PROG[16*i +: 16];
  end

  assign opcode = opcode_e'(instr[OPC_HI:OPC_LO]);
  assign rd     = instr[RD_HI:RD_LO];
  assign rs1    = instr[RS1_HI:RS1_LO];
  assign rs2    = instr[RS2_HI:RS2_LO];

  assign imm = {{(DATA_W-4){1'b0}}, rs2};
  assign a   = (rs1 == 4'd0) ? '0 : regs[rs1];
  assign b   = (opcode == OP_ADC) ? imm : ((rs2 == 4'd0) ? '0 : regs[rs2]);

  alu #(.DATA_W(DATA_W)) u_alu (
    .op (opcode),
    .a  (a),
    .b  (b),
    .y  (y)
  );

  assign run   = rst_n && (state_q == ST_RUN);
  assign wr_en = run && is_alu_op(opcode) && (rd != 4'd0);

  assign wr_en_o   = wr_en;
  assign wr_addr_o = wr_en ? rd : 4'd0;
  assign wr_data_o = wr_en ? y : '0;
  assign pc_o      = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next = state_q;
    if (state_q == ST_RUN && opcode == OP_HALT) state_next = ST_HALTED;
  end

  always_comb begin
    halt_o = (state_q == ST_HALTED);
  end

  // HALT itself retires like any non-branch, so PC settles one past it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (state_q == ST_RUN) begin
      if (opcode == OP_B) pc <= instr[PC_W-1:0];
      else                pc <= pc + {{(PC_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[rd] <= y;
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: the Fibonacci ROM plus a small custom program
// covering r0 writes, SUB wrap, logic ops, unknown opcodes and HALT/reset.
module tb_cpu_core;
  import cpu_pkg::*;

  localparam logic [16*PROG_LEN-1:0] TST_PROG = {
    16'hF000, 16'h9700, 16'h5642, 16'h6412,
    16'h2102, 16'h1302, 16'h4201, 16'h4005
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_f, rst_n_t;
  logic [7:0]  f_pc, t_pc;
  logic        f_en, t_en, f_halt, t_halt;
  logic [3:0]  f_addr, t_addr;
  logic [15:0] f_data, t_data;

  int ncmp = 0;
  int nerr = 0;

  cpu_core u_fib (
    .clk(clk), .rst_n(rst_n_f), .pc_o(f_pc), .wr_en_o(f_en),
    .wr_addr_o(f_addr), .wr_data_o(f_data), .halt_o(f_halt)
  );

  cpu_core #(.PROG(TST_PROG)) u_tst (
    .clk(clk), .rst_n(rst_n_t), .pc_o(t_pc), .wr_en_o(t_en),
    .wr_addr_o(t_addr), .wr_data_o(t_data), .halt_o(t_halt)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic        exp_en   [8];
  logic [3:0]  exp_addr [8];
  logic [15:0] exp_data [8];
  logic [7:0]  exp_pc;
  logic [15:0] p, q;
  logic        seen_wrap, found4;
  int          nr1;

  initial begin
    exp_en   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_addr = '{4'd0, 4'd2, 4'd3, 4'd1, 4'd4, 4'd6, 4'd0, 4'd0};
    exp_data = '{16'h0000, 16'h0001, 16'h0001, 16'hFFFF,
                 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0000};

    rst_n_f = 1'b0;
    rst_n_t = 1'b0;
    @(negedge clk);
    step();
    step();
    ncmp++; if (f_pc !== 8'd0) begin nerr++; $error("FAIL rst_f_pc: observed %0h expected %0h", f_pc, 8'd0); end
    ncmp++; if (f_halt !== 1'b0) begin nerr++; $error("FAIL rst_f_halt: observed %0h expected %0h", f_halt, 1'b0); end
    ncmp++; if (f_en !== 1'b0) begin nerr++; $error("FAIL rst_f_en: observed %0h expected %0h", f_en, 1'b0); end
    ncmp++; if (t_pc !== 8'd0) begin nerr++; $error("FAIL rst_t_pc: observed %0h expected %0h", t_pc, 8'd0); end
    ncmp++; if (t_halt !== 1'b0) begin nerr++; $error("FAIL rst_t_halt: observed %0h expected %0h", t_halt, 1'b0); end

    // Custom program: one row per instruction, then HALT freeze.
    rst_n_t = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      ncmp++; if (t_pc !== 8'(k)) begin nerr++; $error("FAIL t_pc: observed %0h expected %0h", t_pc, 8'(k)); end
      ncmp++; if (t_en !== exp_en[k]) begin nerr++; $error("FAIL t_en: observed %0h expected %0h", t_en, exp_en[k]); end
      ncmp++; if (t_addr !== exp_addr[k]) begin nerr++; $error("FAIL t_addr: observed %0h expected %0h", t_addr, exp_addr[k]); end
      ncmp++; if (t_data !== exp_data[k]) begin nerr++; $error("FAIL t_data: observed %0h expected %0h", t_data, exp_data[k]); end
      ncmp++; if (t_halt !== 1'b0) begin nerr++; $error("FAIL t_halt_run: observed %0h expected %0h", t_halt, 1'b0); end
      step();
    end
    ncmp++; if (t_halt !== 1'b1) begin nerr++; $error("FAIL t_halt_set: observed %0h expected %0h", t_halt, 1'b1); end
    ncmp++; if (t_pc !== 8'd8) begin nerr++; $error("FAIL t_pc_halt: observed %0h expected %0h", t_pc, 8'd8); end
    for (int k = 0; k < 3; k++) begin
      step();
      ncmp++; if (t_pc !== 8'd8) begin nerr++; $error("FAIL t_pc_frozen: observed %0h expected %0h", t_pc, 8'd8); end
      ncmp++; if (t_halt !== 1'b1) begin nerr++; $error("FAIL t_halt_hold: observed %0h expected %0h", t_halt, 1'b1); end
      ncmp++; if (t_en !== 1'b0) begin nerr++; $error("FAIL t_en_halted: observed %0h expected %0h", t_en, 1'b0); end
    end

    // Reset while halted, then restart from address 0.
    rst_n_t = 1'b0;
    step();
    ncmp++; if (t_pc !== 8'd0) begin nerr++; $error("FAIL t_rst_pc: observed %0h expected %0h", t_pc, 8'd0); end
    ncmp++; if (t_halt !== 1'b0) begin nerr++; $error("FAIL t_rst_halt: observed %0h expected %0h", t_halt, 1'b0); end
    rst_n_t = 1'b1;
    #1;
    ncmp++; if (t_en !== 1'b0) begin nerr++; $error("FAIL t_restart_en0: observed %0h expected %0h", t_en, 1'b0); end
    step();
    ncmp++; if (t_pc !== 8'd1) begin nerr++; $error("FAIL t_restart_pc: observed %0h expected %0h", t_pc, 8'd1); end
    ncmp++; if (t_data !== 16'h0001) begin nerr++; $error("FAIL t_restart_data: observed %0h expected %0h", t_data, 16'h0001); end

    // Fibonacci program.
    rst_n_f = 1'b1;
    #1;
    ncmp++; if (f_en !== 1'b1) begin nerr++; $error("FAIL f_first_en: observed %0h expected %0h", f_en, 1'b1); end
    ncmp++; if (f_addr !== 4'd1) begin nerr++; $error("FAIL f_first_addr: observed %0h expected %0h", f_addr, 4'd1); end
    ncmp++; if (f_data !== 16'h0001) begin nerr++; $error("FAIL f_first_data: observed %0h expected %0h", f_data, 16'h0001); end
    exp_pc = 8'd0;
    p = 16'd1;
    q = 16'd2;
    seen_wrap = 1'b0;
    nr1 = 0;
    for (int c = 0; c < 160; c++) begin
      ncmp++; if (f_pc !== exp_pc) begin nerr++; $error("FAIL f_pc: observed %0h expected %0h", f_pc, exp_pc); end
      if (f_en && f_addr == 4'd1) begin
        ncmp++; if (f_data !== p) begin nerr++; $error("FAIL f_r1: observed %0h expected %0h", f_data, p); end
        if (f_data == 16'h2511) seen_wrap = 1'b1;
        {p, q} = {q, 16'(p + q)};
        nr1++;
      end
      if (c == 39) begin
        ncmp++; if (nr1 !== 9) begin nerr++; $error("FAIL f_r1_count40: observed %0h expected %0h", nr1, 9); end
      end
      exp_pc = (exp_pc == 8'd6) ? 8'd2 : exp_pc + 8'd1;
      step();
    end
    ncmp++; if (seen_wrap !== 1'b1) begin nerr++; $error("FAIL f_wrap_seen: observed %0h expected %0h", seen_wrap, 1'b1); end
    ncmp++; if (f_halt !== 1'b0) begin nerr++; $error("FAIL f_halt_low: observed %0h expected %0h", f_halt, 1'b0); end

    // Reset mid-run at pc 4.
    found4 = 1'b0;
    for (int c = 0; c < 10 && !found4; c++) begin
      if (f_pc == 8'd4) found4 = 1'b1;
      else step();
    end
    ncmp++; if (found4 !== 1'b1) begin nerr++; $error("FAIL f_reach_pc4: observed %0h expected %0h", found4, 1'b1); end
    rst_n_f = 1'b0;
    #1;
    ncmp++; if (f_en !== 1'b0) begin nerr++; $error("FAIL f_rst_en: observed %0h expected %0h", f_en, 1'b0); end
    ncmp++; if (f_addr !== 4'd0) begin nerr++; $error("FAIL f_rst_addr: observed %0h expected %0h", f_addr, 4'd0); end
    ncmp++; if (f_data !== 16'h0000) begin nerr++; $error("FAIL f_rst_data: observed %0h expected %0h", f_data, 16'h0000); end
    step();
    ncmp++; if (f_pc !== 8'd0) begin nerr++; $error("FAIL f_midrst_pc: observed %0h expected %0h", f_pc, 8'd0); end
    ncmp++; if (f_halt !== 1'b0) begin nerr++; $error("FAIL f_midrst_halt: observed %0h expected %0h", f_halt, 1'b0); end
    for (int i = 0; i < 16; i++) begin
      ncmp++; if (u_fib.regs[i] !== 16'h0000) begin nerr++; $error("FAIL f_reg_clear: observed %0h expected %0h", u_fib.regs[i], 16'h0000); end
    end
    rst_n_f = 1'b1;
    #1;
    ncmp++; if (f_data !== 16'h0001) begin nerr++; $error("FAIL f_rerun_data: observed %0h expected %0h", f_data, 16'h0001); end
    step();
    step();
    ncmp++; if (f_pc !== 8'd2) begin nerr++; $error("FAIL f_rerun_pc2: observed %0h expected %0h", f_pc, 8'd2); end
    ncmp++; if (f_data !== 16'h0002) begin nerr++; $error("FAIL f_rerun_add: observed %0h expected %0h", f_data, 16'h0002); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
